// File: rtl/car_cmd_arbiter_if.sv
// car_cmd_arbiter_if
//   Command bus between the receiver/keypad front-ends and the arbiter, and
//   between the arbiter and the motor PWM controller.
//   master : front-end side. Drives rmt_cmd/rmt_vld/loc_cmd and observes the arbiter outputs.
//   slave  : arbiter side.
//   rmt_cmd[6:0] rmt_vld : remote word plus its one-cycle strobe
//   loc_cmd[6:0]         : keypad word, level-held
//   cmd_out[6:0] cmd_upd : registered motor command plus its load pulse
//   owner[1:0] failsafe  : current owner and failsafe flag
//   err_cnt[7:0]         : count of rejected words
interface car_cmd_arbiter_if;
  logic [6:0] rmt_cmd;
  logic       rmt_vld;
  logic [6:0] loc_cmd;
  logic [6:0] cmd_out;
  logic       cmd_upd;
  logic [1:0] owner;
  logic       failsafe;
  logic [7:0] err_cnt;

  modport master (
    output rmt_cmd, rmt_vld, loc_cmd,
    input  cmd_out, cmd_upd, owner, failsafe, err_cnt
  );

  modport slave (
    input  rmt_cmd, rmt_vld, loc_cmd,
    output cmd_out, cmd_upd, owner, failsafe, err_cnt
  );
endinterface

// File: rtl/car_cmd_arbiter.sv
// car_cmd_arbiter
//   Arbitrates remote (radio) and local (keypad) motion commands onto one
//   7-bit motor command bus. Remote has priority over local. When remote
//   preempts local, a STOP dead-time of DEAD_CYC cycles is inserted first.
//   If no remote command is accepted for HOLD_CYC cycles, the arbiter enters FAILSAFE (STOP).
//   Ports:
//     clk, rst_n : clock; asynchronous active-low reset
//     bus        : car_cmd_arbiter_if.slave (see the interface file)
//   Parameters: HOLD_CYC (>=2), DEAD_CYC (>=1)
//   Build option: CAR_CMD_ARBITER_ERRCNT_EN enables the saturating rejected-word counter.
//     When it is not defined, err_cnt reads 0.
module car_cmd_arbiter #(
  parameter int HOLD_CYC = 50_000_000,
  parameter int DEAD_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  car_cmd_arbiter_if.slave  bus
);

  localparam int TMAX = (HOLD_CYC > DEAD_CYC) ? HOLD_CYC : DEAD_CYC;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] DEAD_LAST = TW'(DEAD_CYC - 1);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);
  localparam logic [6:0]    STOP      = 7'b100_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_REMOTE, S_LOCAL, S_GAP, S_FAILSAFE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [6:0]    r_cmd, w_cmd_nxt;
  logic [6:0]    r_pend, w_pend_nxt;
  logic [6:0]    r_loc_q;
  logic          r_upd, w_load;
  logic [TW-1:0] r_tmr, w_tmr_nxt;

  logic w_rmt_ok, w_rmt_bad, w_loc_req, w_loc_ok, w_loc_bad;

  function automatic logic f_valid(input logic [6:0] c);
    return c[6] && (c[5:4] == 2'b00) && (c[3:0] <= 4'd8);
  endfunction

  assign w_rmt_ok  = bus.rmt_vld &&  f_valid(bus.rmt_cmd);
  assign w_rmt_bad = bus.rmt_vld && !f_valid(bus.rmt_cmd);
  assign w_loc_req = (bus.loc_cmd != r_loc_q);
  assign w_loc_ok  = w_loc_req &&  f_valid(bus.loc_cmd);
  assign w_loc_bad = w_loc_req && !f_valid(bus.loc_cmd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cmd   <= STOP;
      r_upd   <= 1'b0;
      r_pend  <= STOP;
      r_tmr   <= '0;
      r_loc_q <= STOP;
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
      r_upd   <= w_load;
      r_pend  <= w_pend_nxt;
      r_tmr   <= w_tmr_nxt;
      r_loc_q <= bus.loc_cmd;   // tracks the keypad every cycle, accepted or not
    end
  end

  // In every branch, the remote strobe is tested first, so it wins against
  // a simultaneous local request and against timer expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_load      = 1'b0;
    w_pend_nxt  = r_pend;
    w_tmr_nxt   = r_tmr;
    case (r_state)
      S_IDLE, S_FAILSAFE: begin
        if (w_rmt_ok) begin
          w_state_nxt = S_REMOTE;
          w_cmd_nxt   = bus.rmt_cmd;
          w_load      = 1'b1;
          w_tmr_nxt   = '0;
        end else if (w_loc_ok) begin
          w_state_nxt = S_LOCAL;
          w_cmd_nxt   = bus.loc_cmd;
          w_load      = 1'b1;
          w_tmr_nxt   = '0;
        end
      end
      S_REMOTE: begin
        if (w_rmt_ok) begin
          w_cmd_nxt = bus.rmt_cmd;
          w_load    = 1'b1;
          w_tmr_nxt = '0;
        end else if (r_tmr == HOLD_LAST) begin
          w_state_nxt = S_FAILSAFE;
          w_cmd_nxt   = STOP;
          w_load      = 1'b1;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + TMR_ONE;
        end
      end
      S_LOCAL: begin
        if (w_rmt_ok) begin
          w_state_nxt = S_GAP;
          w_pend_nxt  = bus.rmt_cmd;
          w_cmd_nxt   = STOP;
          w_load      = 1'b1;
          w_tmr_nxt   = '0;
        end else if (w_loc_ok) begin
          w_cmd_nxt = bus.loc_cmd;
          w_load    = 1'b1;
        end
      end
      S_GAP: begin
        if (w_rmt_ok) w_pend_nxt = bus.rmt_cmd;
        if (r_tmr == DEAD_LAST) begin
          // A strobe on the last dead-time cycle is the one that gets loaded.
          w_state_nxt = S_REMOTE;
          w_cmd_nxt   = w_pend_nxt;
          w_load      = 1'b1;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + TMR_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cmd_nxt   = STOP;
        w_load      = 1'b1;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  assign bus.cmd_out  = r_cmd;
  assign bus.cmd_upd  = r_upd;
  assign bus.owner    = (r_state == S_REMOTE) ? 2'b01 :
                        (r_state == S_LOCAL)  ? 2'b10 : 2'b00;
  assign bus.failsafe = (r_state == S_FAILSAFE);

`ifdef CAR_CMD_ARBITER_ERRCNT_EN
  // A remote word and a keypad word that are both rejected in the same cycle count as two errors.
  logic [7:0] r_err;
  logic [8:0] w_err_sum;
  assign w_err_sum = {1'b0, r_err} + {8'd0, w_rmt_bad} + {8'd0, w_loc_bad};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 8'd0;
    else        r_err <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
  end

  assign bus.err_cnt = r_err;
`else
  logic w_unused_err;
  assign w_unused_err = w_rmt_bad ^ w_loc_bad;
  assign bus.err_cnt  = 8'd0;
`endif

endmodule
